// File: rtl/freq_div_ctrl_pkg.sv
// Shared constants for the divider run controller: FSM state encodings and
// divisor limits.
package freq_div_ctrl_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_STOP_PEND = 2'd2;

  localparam int DEFAULT_DIV_C = 32;
  localparam int MIN_DIV       = 2;

endpackage

// File: rtl/freq_div_ctrl_if.sv
// Configuration/control bus of the divider run controller. The master side
// drives requests; the slave side (the controller) drives status and wave.
interface freq_div_ctrl_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               busy;
  logic               tick;
  logic               div_out;
  logic               done;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, busy, tick, div_out, done
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, busy, tick, div_out, done
  );

endinterface

// File: rtl/freq_div_ctrl_div_period_counter.sv
// Period counter: counts 0..active_div-1 while enabled and decodes the
// per-period tick and the square-wave level from the registered count.
module freq_div_ctrl_div_period_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] active_div,
  output logic             tick,
  output logic             div_out
);

  logic [CNT_W-1:0] count_reg;
  logic             at_wrap;

  assign at_wrap = (count_reg == active_div - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= at_wrap ? '0 : count_reg + CNT_W'(1);
    end
  end

  assign tick    = enable && at_wrap;
  // Low half first; an odd divisor gives the extra cycle to the high phase.
  assign div_out = enable && (count_reg >= (active_div >> 1));

endmodule

// File: rtl/freq_div_ctrl.sv
// Run controller for the programmable frequency divider: start/stop/burst
// sequencing and boundary-aligned divisor updates through a shadow register.
module freq_div_ctrl
  import freq_div_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_C,
  parameter int BURST_W     = 8
) (
  input logic           clk,
  input logic           rst_n,
  freq_div_ctrl_if.slave bus
);

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   active_div_reg;
  logic [CNT_W-1:0]   shadow_reg;
  logic               shadow_full_reg;
  logic [BURST_W-1:0] burst_len_reg;
  logic [BURST_W-1:0] period_cnt_reg;
  logic               done_reg;

  logic               busy;
  logic               tick;
  logic               div_out;
  logic               cfg_fire;
  logic               run_go;
  logic               last_period;
  logic               end_run;
  logic [CNT_W-1:0]   div_in;

  assign busy        = (state_reg != ST_IDLE);
  assign cfg_fire    = bus.cfg_valid && !shadow_full_reg;
  assign div_in      = (bus.cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : bus.cfg_div;
  assign run_go      = (state_reg == ST_IDLE) && bus.start && !bus.stop;
  assign last_period = (burst_len_reg != '0) &&
                       (period_cnt_reg == burst_len_reg - BURST_W'(1));
  assign end_run     = tick && ((state_reg == ST_STOP_PEND) || last_period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      active_div_reg  <= CNT_W'(DEFAULT_DIV);
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      burst_len_reg   <= '0;
      period_cnt_reg  <= '0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= end_run;
      case (state_reg)
        ST_IDLE: begin
          if (cfg_fire) active_div_reg <= div_in;
          if (run_go) begin
            state_reg      <= ST_RUN;
            burst_len_reg  <= bus.cfg_burst;
            period_cnt_reg <= '0;
          end
        end
        ST_RUN, ST_STOP_PEND: begin
          if (end_run) begin
            // Anything still waiting for a boundary takes effect as we go idle.
            state_reg       <= ST_IDLE;
            period_cnt_reg  <= '0;
            shadow_full_reg <= 1'b0;
            if (cfg_fire) active_div_reg <= div_in;
            else if (shadow_full_reg) active_div_reg <= shadow_reg;
          end else begin
            if (cfg_fire) begin
              shadow_reg      <= div_in;
              shadow_full_reg <= 1'b1;
            end else if (tick && shadow_full_reg) begin
              active_div_reg  <= shadow_reg;
              shadow_full_reg <= 1'b0;
            end
            if (tick && (burst_len_reg != '0)) period_cnt_reg <= period_cnt_reg + BURST_W'(1);
            if ((state_reg == ST_RUN) && bus.stop) state_reg <= ST_STOP_PEND;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  freq_div_ctrl_div_period_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (busy),
    .clear      (run_go),
    .active_div (active_div_reg),
    .tick       (tick),
    .div_out    (div_out)
  );

  assign bus.cfg_ready = !shadow_full_reg;
  assign bus.busy      = busy;
  assign bus.tick      = tick;
  assign bus.div_out   = div_out;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: expected tick/done cycles are queued when a run is
// launched and matched against the DUT pulses as they appear.
module tb_freq_div_ctrl;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tick_q[$];
  int   done_q[$];

  freq_div_ctrl_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus_if ();

  freq_div_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (32),
    .BURST_W     (BURST_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Output monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin : monitor
    int e;
    if (rst_n) begin
      if (bus_if.tick) begin
        e = (tick_q.size() != 0) ? tick_q.pop_front() : -1;
        check("tick_cycle", cyc, e);
      end
      if (bus_if.done) begin
        e = (done_q.size() != 0) ? done_q.pop_front() : -1;
        check("done_cycle", cyc, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic cfg_idle(input int d);
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_div   = CNT_W'(d);
    step();
    bus_if.cfg_valid = 1'b0;
  endtask

  task automatic start_run(input int b, output int k);
    k = cyc;
    bus_if.start     = 1'b1;
    bus_if.cfg_burst = BURST_W'(b);
    step();
    bus_if.start = 1'b0;
  endtask

  task automatic push_burst(input int k, input int d, input int n);
    for (int i = 1; i <= n; i++) tick_q.push_back(k + i * d);
    done_q.push_back(k + n * d + 1);
  endtask

  initial begin : stim
    int k;
    int k2;
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_div   = '0;
    bus_if.cfg_burst = '0;
    bus_if.start     = 1'b0;
    bus_if.stop      = 1'b0;

    repeat (3) step();
    check("rst_cfg_ready", bus_if.cfg_ready, 1);
    check("rst_busy", bus_if.busy, 0);
    check("rst_tick", bus_if.tick, 0);
    check("rst_div_out", bus_if.div_out, 0);
    check("rst_done", bus_if.done, 0);
    rst_n = 1'b1;
    step();

    // Continuous run at the default divisor, then graceful stop.
    start_run(0, k);
    tick_q.push_back(k + 32);
    tick_q.push_back(k + 64);
    for (int j = 1; j <= 32; j++) begin
      goto(k + j);
      check("t1_div_out", bus_if.div_out, ((j - 1) >= 16) ? 1 : 0);
    end
    check("t1_busy", bus_if.busy, 1);
    goto(k + 69);
    bus_if.stop = 1'b1;
    tick_q.push_back(k + 96);
    done_q.push_back(k + 97);
    step();
    bus_if.stop = 1'b0;
    goto(k + 97);
    check("t1_busy_end", bus_if.busy, 0);

    // Burst of 3 periods at div=10.
    cfg_idle(10);
    check("t2_cfg_ready", bus_if.cfg_ready, 1);
    start_run(3, k);
    push_burst(k, 10, 3);
    goto(k + 30);
    check("t2_busy_last", bus_if.busy, 1);
    goto(k + 31);
    check("t2_busy_done", bus_if.busy, 0);
    goto(k + 35);

    // Mid-period update 10 -> 6, then an update offered on a tick is held.
    start_run(0, k);
    tick_q.push_back(k + 10);
    tick_q.push_back(k + 16);
    tick_q.push_back(k + 22);
    goto(k + 4);
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_div   = 16'd6;
    step();
    bus_if.cfg_valid = 1'b0;
    check("t3_ready_full", bus_if.cfg_ready, 0);
    goto(k + 9);
    check("t3_ready_held", bus_if.cfg_ready, 0);
    goto(k + 11);
    check("t3_ready_back", bus_if.cfg_ready, 1);
    goto(k + 16);
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_div   = 16'd10;
    step();
    bus_if.cfg_valid = 1'b0;
    check("t3_ready_tick_xfer", bus_if.cfg_ready, 0);
    goto(k + 18);
    bus_if.stop = 1'b1;
    done_q.push_back(k + 23);
    step();
    bus_if.stop = 1'b0;
    goto(k + 23);
    check("t3_ready_idle", bus_if.cfg_ready, 1);
    check("t3_busy_idle", bus_if.busy, 0);
    start_run(1, k);
    push_burst(k, 10, 1);
    goto(k + 13);

    // Stop at count=3 with div=8; repeated stop in STOP_PEND is ignored.
    cfg_idle(8);
    start_run(0, k);
    goto(k + 4);
    bus_if.stop = 1'b1;
    tick_q.push_back(k + 8);
    done_q.push_back(k + 9);
    step();
    bus_if.stop = 1'b0;
    goto(k + 6);
    check("t4_busy_pend", bus_if.busy, 1);
    bus_if.stop = 1'b1;
    step();
    bus_if.stop = 1'b0;
    goto(k + 9);
    check("t4_busy_end", bus_if.busy, 0);
    goto(k + 30);
    check("t4_busy_quiet", bus_if.busy, 0);

    // div=1 clamps to 2; start while busy ignored; stop on final tick.
    cfg_idle(1);
    start_run(4, k);
    push_burst(k, 2, 4);
    for (int j = 1; j <= 8; j++) begin
      goto(k + j);
      check("t5_div_out", bus_if.div_out, (j - 1) % 2);
      bus_if.start = (j == 3);
      bus_if.stop  = (j == 8);
    end
    goto(k + 9);
    bus_if.stop = 1'b0;
    check("t5_busy_end", bus_if.busy, 0);
    goto(k + 12);

    bus_if.start = 1'b1;
    bus_if.stop  = 1'b1;
    step();
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    check("t5_start_stop_idle", bus_if.busy, 0);
    repeat (4) step();
    check("t5_still_idle", bus_if.busy, 0);

    cfg_idle(0);
    start_run(1, k);
    push_burst(k, 2, 1);
    goto(k + 5);

    // Reset mid-run with a pending shadow value.
    cfg_idle(10);
    start_run(0, k);
    tick_q.push_back(k + 10);
    goto(k + 12);
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_div   = 16'd20;
    step();
    bus_if.cfg_valid = 1'b0;
    check("t6_ready_full", bus_if.cfg_ready, 0);
    goto(k + 17);
    check("t6_div_out_pre", bus_if.div_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", bus_if.busy, 0);
    check("t6_tick", bus_if.tick, 0);
    check("t6_div_out", bus_if.div_out, 0);
    check("t6_done", bus_if.done, 0);
    check("t6_cfg_ready", bus_if.cfg_ready, 1);
    goto(k + 25);
    rst_n = 1'b1;
    step();
    start_run(1, k2);
    push_burst(k2, 32, 1);
    goto(k2 + 36);

    check("tick_q_empty", tick_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/freq_div_ctrl.md
Name: freq_div_ctrl

Overview:
- Run controller for the programmable counter-based frequency divider: sequences start, stop and finite bursts.
- Accepts divide-ratio updates through a valid/ready handshake and applies them glitch-free, only at period boundaries.
- Produces the divided square wave, a per-period tick and a completion pulse.
- Sits between the configuration/control logic and any consumer of the slowed clock-enable.

Parameters:
- CNT_W, 16, width of the period counter and of the divisor.
- DEFAULT_DIV, 32, divisor loaded at reset; reproduces the fixed divide-by-32 behaviour.
- BURST_W, 8, width of the burst-length field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  new divisor offered.
- cfg_ready  out  1  controller can accept a divisor.
- cfg_div  in  CNT_W  requested divisor, in input clock cycles per output period.
- cfg_burst  in  BURST_W  number of periods to run; 0 means continuous. Sampled with start.
- start  in  1  single-cycle run request.
- stop  in  1  single-cycle graceful-stop request.
- busy  out  1  high in RUN or STOP_PEND.
- tick  out  1  one-cycle pulse in the last cycle of each output period.
- div_out  out  1  divided square wave.
- done  out  1  one-cycle pulse when a run ends.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, count=0, active_div=DEFAULT_DIV, shadow empty, period count=0.
  - Outputs: cfg_ready=1, busy=0, tick=0, div_out=0, done=0.
- States:
  - IDLE -> RUN on start when stop=0. count is cleared and the burst length is latched; the first counted cycle is the cycle after start.
  - RUN -> STOP_PEND on stop.
  - RUN -> IDLE at the tick that completes the final burst period.
  - STOP_PEND -> IDLE at the next tick.
- Counter:
  - count increments every cycle in RUN/STOP_PEND.
  - When count == active_div-1: tick=1 (decoded from the registered count) and count wraps to 0 on the next edge.
- div_out:
  - 1 while busy and count >= (active_div>>1), else 0.
  - For div=32: 16 cycles low, then 16 cycles high.
  - For odd divisors the high phase is one cycle longer.
- Divisor width rule: cfg_div values 0 and 1 are clamped to 2. No other range checks.
- Configuration handshake: a transfer occurs when cfg_valid && cfg_ready.
  - In IDLE: active_div is updated immediately and cfg_ready stays 1.
  - In RUN/STOP_PEND: the value goes to the shadow register and cfg_ready drops to 0 while the shadow is full.
  - The shadow loads into active_div on the edge after a tick, then empties, and cfg_ready returns to 1 on that edge.
  - A transfer in the same cycle as a tick is held until the following boundary.
  - A full shadow at the end of a run is applied on entry to IDLE.
- Burst:
  - With a non-zero burst length, the period count increments on each tick.
  - The tick with period count == burst-1 ends the run.
- done:
  - Registered pulse, high in the cycle after the run-ending tick. busy=0 in that same cycle.
- Simultaneous events:
  - start and stop together in IDLE: stop wins and start is ignored.
  - start while busy is ignored.
  - stop in STOP_PEND or IDLE has no effect.
  - stop on the final burst tick: the run ends normally with a single done pulse.
- Reset mid-run: immediate return to the reset state. No done pulse is generated and a pending shadow value is discarded.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, RUN, STOP_PEND);
  - the DEFAULT_DIV constant;
  - the minimum-divisor constant (2).
- One sub-module is natural: div_period_counter.
  - Contents: count register, wrap compare, tick, div_out decode.
  - Inputs: enable, clear, active_div.
  - The FSM, shadow register and handshake stay in freq_div_ctrl.

Test Plan:
- Reset release, start with cfg_burst=0 and default divisor -> div_out low 16 cycles / high 16 cycles; tick every 32 cycles; busy=1.
- IDLE config cfg_div=10, then start with cfg_burst=3 -> exactly 3 ticks spaced 10 cycles; done one cycle after the 3rd tick; busy=0.
- Mid-period update to cfg_div=6 during a div=10 run -> cfg_ready=0 until the boundary; the current period completes at 10 cycles, subsequent periods are 6; cfg_ready returns to 1.
- stop at count=3 with div=8 -> STOP_PEND; tick at count=7; then done and IDLE; no further ticks.
- cfg_div=1 -> period of 2 cycles; div_out alternates 0/1. Simultaneous start+stop in IDLE -> remains IDLE, busy=0.
- rst_n pulsed low mid-run with a shadow pending -> all outputs 0 immediately; active_div=32; no done pulse.
